uart_rx_ip: RTL and testbench
=============================

Name: uart_rx_ip

Overview:
- Memory-mapped UART receiver peripheral; the receive-side counterpart of the SoC's UART transmitter peripheral.
- Deserialises 8N1 frames from a pin into a small FIFO that the CPU reads over the local bus.
- Sits beside the GPIO/UART-TX peripherals behind the device selector; the selector qualifies ren/wen, so the block decodes only the low address bits.

Parameters:
- CLKS_PER_BIT, 104, reset value of the DIVIDER register (clock cycles per bit; 12 MHz / 115200).
- FIFO_DEPTH, 8, RX FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- waddr  input  32  write address; bits [3:2] select the register
- wdata  input  32  write data
- wen  input  1  write enable (already qualified by the selector)
- wstrb  input  4  byte strobes; a write is accepted only if wstrb[0]=1
- wready  output  1  write acknowledge
- raddr  input  32  read address; bits [3:2] select the register
- ren  input  1  read enable (already qualified by the selector)
- rdata  output  32  read data
- rvalid  output  1  read data valid
- i_uart_rx  input  1  serial input; idle high

Behaviour:
- Reset values: rdata=0, rvalid=0, wready=0, FIFO empty, all sticky flags 0, DIVIDER=CLKS_PER_BIT, FSM=IDLE.
- Input path: i_uart_rx passes through a 2-flop synchronizer. Both flops reset to 1.
- Register map:
  - 0x0 DATA (read-only): [7:0] FIFO head, [8]=1 if the FIFO was non-empty.
    - A read with the FIFO non-empty pops one entry.
    - A read with the FIFO empty returns 0 and has no side effect.
  - 0x4 STATUS: [0] not_empty, [1] full, [2] overrun, [3] frame_err, [4] parity_err; [31:5]=0.
    - Writing 1 to bits [4:2] clears them (write-one-to-clear).
    - If a clear and a set of the same flag happen in one cycle, set wins.
  - 0x8 DIVIDER: [15:0] read/write; [31:16] read 0. A written value below 4 is stored as 4.
  - 0xC: reads 0; writes are ignored.
- Bus timing:
  - rdata and rvalid are registered, one cycle after ren. rvalid is a 1-cycle pulse.
  - wready pulses one cycle after wen.
  - The pop and W1C side effects take effect on the ren/wen cycle.
- Receive FSM (the bit counter reloads with the divider latched at the start bit; a DIVIDER write mid-frame applies from the next frame):
  - IDLE: on synchronized rx=0, load half-divider → START.
  - START: at half-bit, rx=0 → DATA and reload the full divider; rx=1 → glitch, back to IDLE.
  - DATA: sample at each full-bit tick, LSB first, 8 bits → STOP (→ PARITY when the macro is set).
  - STOP: sample at the full-bit tick.
    - rx=1: push the byte → IDLE.
    - rx=0: discard the byte, set frame_err → BREAK.
  - BREAK: wait for rx=1 → IDLE.
- FIFO push onto a full FIFO: drop the byte, set overrun, FIFO contents unchanged.
- Push and pop in the same cycle with the FIFO full: both occur, overrun is not set, count is unchanged.
- Push and pop in the same cycle with the FIFO empty: the read returns [8]=0 and the pushed byte is retained.
- Pointers wrap modulo FIFO_DEPTH. The count has log2(FIFO_DEPTH)+1 bits.
- rst mid-frame: the FSM returns to IDLE, the partial byte is lost, and the FIFO and flags are cleared.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1. The PARITY state samples one extra bit after DATA.
  - If the received bit ≠ XOR of the data bits: set parity_err and discard the byte. The stop bit is still checked.
  - DIVIDER bit [16] is read/write: 1 selects odd parity. It resets to 0.
- Undefined: 8N1 only; STATUS[4] and DIVIDER[16] read 0.

Test Plan:
- Reset, then read 0x8 → rdata=0x00000068 with rvalid one cycle later; read 0x0 → 0x00000000.
- Divider=16, send 0xA5 as 8N1 → STATUS=0x1; read DATA → 0x1A5; next read → 0x000; STATUS=0x0.
- Send 9 bytes 0x01..0x09 without reading → STATUS=0x7; eight reads return 0x01..0x08; write 0x4 to STATUS → overrun clears.
- Frame 0x3C sent with a stop bit of 0 → FIFO stays empty, STATUS=0x8; line held low for 30 bit times, then 0x55 → 0x55 received.
- Low glitch of divider/4 cycles on the idle line → no byte received, no flags set; DIVIDER written to 2 → reads back 4.
- With UART_RX_PARITY_EN defined: 0x07 with wrong even parity → STATUS=0x10, FIFO empty; 0x07 with correct parity → 0x107 read.

Source files
------------

// File: rtl/uart_rx_ip.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding a small RX FIFO read over the local bus.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames with parity checking.
module uart_rx_ip #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  wstrb,
    output logic        wready,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        i_uart_rx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t        state;
    logic          rx_meta, rx_sync;
    logic [15:0]   div_q, frame_div, cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bad;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          ovr, fe, pe;
    logic          tick, push_req, frame_set, parity_set;
    logic          full, not_empty, pop, push_ok, ovr_set, wr_ok;
    logic [2:0]    clr;
    logic          par_odd_rd;
    logic [31:0]   rd_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick      = (cnt == 16'd0);
    assign push_req  = (state == S_STOP) && tick && rx_sync && !par_bad;
    assign frame_set = (state == S_STOP) && tick && !rx_sync;

`ifdef UART_RX_PARITY_EN
    logic par_odd;
    assign par_odd_rd = par_odd;
    assign parity_set = (state == S_PARITY) && tick && (rx_sync != (^shreg ^ par_odd));
`else
    assign par_odd_rd = 1'b0;
    assign parity_set = 1'b0;
`endif

    // Bit timing uses the divider captured at the start edge, so a mid-frame
    // DIVIDER write only affects the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 16'd0;
            frame_div <= 16'(CLKS_PER_BIT);
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            par_bad   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (!rx_sync) begin
                    cnt       <= (div_q >> 1) - 16'd1;
                    frame_div <= div_q;
                    state     <= S_START;
                end
                S_START: if (tick) begin
                    if (!rx_sync) begin
                        state   <= S_DATA;
                        cnt     <= frame_div - 16'd1;
                        bit_idx <= 3'd0;
                        par_bad <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end else cnt <= cnt - 16'd1;
                S_DATA: if (tick) begin
                    shreg   <= {rx_sync, shreg[7:1]};
                    cnt     <= frame_div - 16'd1;
                    bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state <= S_PARITY;
`else
                    if (bit_idx == 3'd7) state <= S_STOP;
`endif
                end else cnt <= cnt - 16'd1;
                S_PARITY: if (tick) begin
                    par_bad <= parity_set;
                    cnt     <= frame_div - 16'd1;
                    state   <= S_STOP;
                end else cnt <= cnt - 16'd1;
                S_STOP: if (tick) state <= rx_sync ? S_IDLE : S_BREAK;
                        else cnt <= cnt - 16'd1;
                S_BREAK: if (rx_sync) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign not_empty = (count != '0);
    assign pop       = ren && (raddr[3:2] == 2'd0) && not_empty;
    assign push_ok   = push_req && (!full || pop);
    assign ovr_set   = push_req && full && !pop;
    assign wr_ok     = wen && wstrb[0];
    assign clr       = (wr_ok && waddr[3:2] == 2'd1) ? wdata[4:2] : 3'd0;

    always_comb begin
        rd_mux = 32'd0;
        case (raddr[3:2])
            2'd0: if (not_empty) rd_mux = {23'd0, 1'b1, mem[rd_ptr]};
            2'd1: rd_mux = {27'd0, pe, fe, ovr, full, not_empty};
            2'd2: rd_mux = {15'd0, par_odd_rd, div_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= 32'd0;
            rvalid <= 1'b0;
            wready <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
            fe     <= 1'b0;
            pe     <= 1'b0;
            div_q  <= 16'(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
            par_odd <= 1'b0;
`endif
        end else begin
            rvalid <= ren;
            rdata  <= ren ? rd_mux : 32'd0;
            wready <= wen;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
            // Set wins over a simultaneous write-one-to-clear.
            ovr <= ovr_set    | (ovr & ~clr[0]);
            fe  <= frame_set  | (fe  & ~clr[1]);
            pe  <= parity_set | (pe  & ~clr[2]);
            if (wr_ok && waddr[3:2] == 2'd2) begin
                div_q <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
`ifdef UART_RX_PARITY_EN
                par_odd <= wdata[16];
`endif
            end
        end
    end

    logic unused_bits;
`ifdef UART_RX_PARITY_EN
    assign unused_bits = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0], wdata[31:17], wstrb[3:1]};
`else
    assign unused_bits = ^{waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0], wdata[31:16], wstrb[3:1]};
`endif
endmodule

// File: tb/tb_uart_rx_ip.sv
// Self-checking bench for uart_rx_ip: directed cases plus randomized frames
// checked against a queue-based FIFO/flag model.
module tb_uart_rx_ip;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] waddr, wdata, raddr, rdata;
    logic        wen, ren, wready, rvalid, rx;
    logic [3:0]  wstrb;

    uart_rx_ip dut (
        .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .wready(wready), .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
        .i_uart_rx(rx)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int div = 104;
    logic       last_rvalid, last_wready;
    logic [7:0] mq[$];
    bit         m_ovr, m_fe, m_pe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_status();
        return {27'd0, m_pe, m_fe, m_ovr, mq.size() == 8, mq.size() != 0};
    endfunction

    function automatic logic [31:0] m_pop();
        if (mq.size() == 0) return 32'd0;
        return {23'd0, 1'b1, mq.pop_front()};
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (mq.size() == 8) m_ovr = 1'b1;
        else mq.push_back(b);
    endfunction

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); raddr = a; ren = 1'b1;
        @(negedge clk); ren = 1'b0;
        d = rdata; last_rvalid = rvalid;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); waddr = a; wdata = d; wstrb = 4'hF; wen = 1'b1;
        @(negedge clk); wen = 1'b0;
        last_wready = wready;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (div) @(negedge clk);
    endtask

    // low_bits=0: good stop bit; otherwise the line stays low that many bit times.
    task automatic send_frame(input logic [7:0] b, input int low_bits, input bit bad_par);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ bad_par);
`endif
        if (low_bits == 0) bit_time(1'b1);
        else repeat (low_bits) bit_time(1'b0);
        rx = 1'b1;
        repeat (2 * div) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input int low_bits, input bit bad_par);
`ifdef UART_RX_PARITY_EN
        if (bad_par) m_pe = 1'b1;
`endif
        if (low_bits != 0) m_fe = 1'b1;
        else if (!bad_par) m_push(b);
    endtask

    task automatic set_div(input int d);
        bus_wr(32'h8, d);
        div = (d < 4) ? 4 : d;
    endtask

    logic [31:0] d;

    initial begin
        rst = 1'b1; rx = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = 0; wdata = 0; raddr = 0; wstrb = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        bus_rd(32'h8, d); chk("rst_div", d, 32'h68);
        chk("rvalid_pulse", {31'd0, last_rvalid}, 32'd1);
        @(negedge clk); chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
        bus_rd(32'h0, d); chk("rst_data", d, 32'd0);
        bus_rd(32'h4, d); chk("rst_status", d, 32'd0);

        // single byte
        set_div(16);
        chk("wready_pulse", {31'd0, last_wready}, 32'd1);
        bus_rd(32'h8, d); chk("div16", d, 32'd16);
        send_frame(8'hA5, 0, 1'b0); model_frame(8'hA5, 0, 1'b0);
        bus_rd(32'h4, d); chk("a5_status", d, 32'h1);
        bus_rd(32'h0, d); chk("a5_data", d, 32'h1A5); void'(m_pop());
        bus_rd(32'h0, d); chk("a5_empty", d, 32'h0);
        bus_rd(32'h4, d); chk("a5_status2", d, m_status());

        // overrun
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0, 1'b0); model_frame(8'(i), 0, 1'b0);
        end
        bus_rd(32'h4, d); chk("ovr_status", d, 32'h7);
        for (int i = 0; i < 8; i++) begin
            bus_rd(32'h0, d); chk("ovr_data", d, m_pop());
        end
        bus_rd(32'h4, d); chk("ovr_status2", d, 32'h4);
        bus_wr(32'h4, 32'h4); m_ovr = 1'b0;
        bus_rd(32'h4, d); chk("ovr_clear", d, 32'h0);

        // framing error and break
        send_frame(8'h3C, 31, 1'b0); model_frame(8'h3C, 31, 1'b0);
        bus_rd(32'h4, d); chk("fe_status", d, 32'h8);
        send_frame(8'h55, 0, 1'b0); model_frame(8'h55, 0, 1'b0);
        bus_rd(32'h0, d); chk("brk_data", d, 32'h155); void'(m_pop());
        bus_wr(32'h4, 32'h8); m_fe = 1'b0;
        bus_rd(32'h4, d); chk("fe_clear", d, 32'h0);

        // glitch rejection and divider clamp
        rx = 1'b0; repeat (div / 4) @(negedge clk);
        rx = 1'b1; repeat (3 * div) @(negedge clk);
        bus_rd(32'h4, d); chk("glitch_status", d, 32'h0);
        bus_rd(32'h0, d); chk("glitch_data", d, 32'h0);
        set_div(2);
        bus_rd(32'h8, d); chk("div_clamp", d, 32'h4);
        set_div(16);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 0, 1'b1); model_frame(8'h07, 0, 1'b1);
        bus_rd(32'h4, d); chk("par_bad_status", d, 32'h10);
        send_frame(8'h07, 0, 1'b0); model_frame(8'h07, 0, 1'b0);
        bus_rd(32'h0, d); chk("par_ok_data", d, 32'h107); void'(m_pop());
        bus_wr(32'h4, 32'h10); m_pe = 1'b0;
        bus_rd(32'h4, d); chk("par_clear", d, 32'h0);
`endif

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            int n, nrd, low;
            logic [7:0] b;
            set_div($urandom_range(8, 24));
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                low = ($urandom_range(0, 7) == 0) ? 1 : 0;
                send_frame(b, low, 1'b0); model_frame(b, low, 1'b0);
            end
            bus_rd(32'h4, d); chk("rnd_status", d, m_status());
            nrd = $urandom_range(0, mq.size() + 1);
            for (int i = 0; i < nrd; i++) begin
                bus_rd(32'h0, d); chk("rnd_data", d, m_pop());
            end
            bus_wr(32'h4, 32'h1C); m_ovr = 0; m_fe = 0; m_pe = 0;
            bus_rd(32'h4, d); chk("rnd_status2", d, m_status());
        end

        // reset mid-frame clears FIFO, flags and divider
        send_frame(8'h11, 0, 1'b0);
        rx = 1'b0; repeat (3 * div) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0; rx = 1'b1;
        mq.delete(); m_ovr = 0; m_fe = 0; m_pe = 0; div = 104;
        repeat (4) @(negedge clk);
        bus_rd(32'h4, d); chk("midrst_status", d, 32'h0);
        bus_rd(32'h0, d); chk("midrst_data", d, 32'h0);
        bus_rd(32'h8, d); chk("midrst_div", d, 32'h68);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
